grf_bypass: RTL and testbench
=============================

Name: grf_bypass

Overview:
- General register file of the MIPS datapath; sits directly downstream of the write-back selection stage.
- Consumes the write-address (A3) and write-data (RegData) that the write-back muxes produce.
- Provides two combinational read ports to decode, with internal write-to-read bypass so a same-cycle write is visible to readers.
- Emits a registered one-cycle write-trace record per architectural write, used for reference-model comparison.

Parameters:
- DATA_W, 32, register width in bits.
- NREG, 32, number of registers; the address width is fixed at 5, so NREG must be 32.
- RESET_VAL, 32'h0000_0000, value loaded into registers 1..31 on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- we  input  1  write enable from the write-back stage.
- pc  input  32  PC of the instruction performing the write; trace only.
- a1  input  5  read address, port 1 (rs).
- a2  input  5  read address, port 2 (rt).
- a3  input  5  write address (from the A3 select).
- wd  input  DATA_W  write data (from the RegData select).
- rd1  output  DATA_W  read data, port 1.
- rd2  output  DATA_W  read data, port 2.
- trace_valid  output  1  one-cycle pulse: a write committed on the previous edge.
- trace_pc  output  32  PC of the committed write.
- trace_reg  output  5  register index written.
- trace_data  output  DATA_W  value written.

Behaviour:
- Storage: 31 flops, regs[1..31]. Register $0 is not stored.
- Reset (asynchronous, active-high):
  - regs[1..31] = RESET_VAL.
  - trace_valid = 0; trace_pc = 0; trace_reg = 0; trace_data = 0.
  - Reset takes effect immediately, independent of clk. It overrides any write in progress: a write whose edge coincides with reset asserted is discarded.
- Write (rising edge of clk, reset low):
  - If we==1 and a3!=0, then regs[a3] <= wd.
  - If we==1 and a3==0, the write is silently dropped and no trace is produced.
- Read (combinational, zero latency):
  - rd1 = 0 if a1==0.
  - Otherwise rd1 = wd if we==1 and a3==a1.
  - Otherwise rd1 = regs[a1].
  - rd2 follows the same rules using a2.
  - The bypass is priority over stored contents. It yields the new value in the same cycle as the write, before the edge.
- Simultaneous events:
  - a1==a2==a3 with a valid write: both read ports return wd.
  - Back-to-back writes to the same register: the last edge wins. Each write produces its own trace pulse.
- Trace (registered, 1-cycle latency):
  - On each rising edge: trace_valid <= (we && a3!=0).
  - When that condition is true, trace_pc, trace_reg and trace_data are loaded with pc, a3 and wd.
  - Otherwise trace_pc, trace_reg and trace_data hold their previous values.
  - trace_valid is high for exactly one cycle per committed write.
- Constraints:
  - No X propagation: every output is driven in all cases.
  - No latches: the read path is a pure mux.

Test Plan:
- Reset: assert reset mid-cycle after writing 32'hDEAD_BEEF to $5 -> rd1 (a1=5) reads 0 immediately, before the next edge; all trace_* outputs are 0.
- Basic write/read: we=1, a3=8, wd=32'h0000_1234, pc=32'h0000_3000 for one edge, then we=0, a1=8 -> rd1=32'h0000_1234. One cycle after the edge: trace_valid=1, trace_reg=8, trace_pc=32'h0000_3000, trace_data=32'h0000_1234; the following cycle trace_valid=0.
- $0 hardwire: we=1, a3=0, wd=32'hFFFF_FFFF, a1=0 -> rd1=0 before and after the edge; trace_valid stays 0.
- Bypass: $9 holds 32'h11. Set we=1, a3=9, wd=32'h22, a1=9, a2=9 -> rd1=rd2=32'h22 before the edge; after the edge with we=0, both still read 32'h22.
- Back-to-back: write $31 with 32'hA then 32'hB on consecutive edges -> trace pulses on two consecutive cycles with data A then B; final rd1 (a1=31) = 32'hB.
- Reset during write: reset asserted across an edge with we=1, a3=4, wd=32'h77 -> after deassertion, $4 reads 0 and no trace pulse occurs.

Source files
------------

// File: rtl/grf_bypass_if.sv
// rtl/grf_bypass_if.sv - write-back, read-port and trace bundle for the register file
interface grf_bypass_if #(
   parameter int DATA_W = 32
);
   logic              we;
   logic [31:0]       pc;
   logic [4:0]        a1;
   logic [4:0]        a2;
   logic [4:0]        a3;
   logic [DATA_W-1:0] wd;
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;
   logic              trace_valid;
   logic [31:0]       trace_pc;
   logic [4:0]        trace_reg;
   logic [DATA_W-1:0] trace_data;

   modport master (
      output we, pc, a1, a2, a3, wd,
      input  rd1, rd2, trace_valid, trace_pc, trace_reg, trace_data
   );

   modport slave (
      input  we, pc, a1, a2, a3, wd,
      output rd1, rd2, trace_valid, trace_pc, trace_reg, trace_data
   );
endinterface

// File: rtl/grf_bypass.sv
// rtl/grf_bypass.sv - MIPS general register file with write-to-read bypass and write trace
module grf_bypass #(
   parameter int                DATA_W    = 32,
   parameter int                NREG      = 32,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic         clk,
   input  logic         reset,
   grf_bypass_if.slave  bus
);

   // $0 is hardwired to zero, so only 1..NREG-1 are stored
   logic [DATA_W-1:0] regs [1:NREG-1];
   logic              commit;

   assign commit = bus.we && (bus.a3 != 5'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 1; i < NREG; i++) begin
            regs[i] <= RESET_VAL;
         end
         bus.trace_valid <= 1'b0;
         bus.trace_pc    <= '0;
         bus.trace_reg   <= '0;
         bus.trace_data  <= '0;
      end else begin
         bus.trace_valid <= commit;
         if (commit) begin
            regs[bus.a3]    <= bus.wd;
            bus.trace_pc    <= bus.pc;
            bus.trace_reg   <= bus.a3;
            bus.trace_data  <= bus.wd;
         end
      end
   end

   // A pending write to the addressed register wins over the stored value
   always_comb begin
      bus.rd1 = '0;
      if (bus.a1 != 5'd0) begin
         if (bus.we && (bus.a3 == bus.a1)) begin
            bus.rd1 = bus.wd;
         end else begin
            bus.rd1 = regs[bus.a1];
         end
      end
   end

   always_comb begin
      bus.rd2 = '0;
      if (bus.a2 != 5'd0) begin
         if (bus.we && (bus.a3 == bus.a2)) begin
            bus.rd2 = bus.wd;
         end else begin
            bus.rd2 = regs[bus.a2];
         end
      end
   end

endmodule

// File: tb/tb_grf_bypass.sv
// tb/tb_grf_bypass.sv - self-checking bench for grf_bypass against a register-array model
module tb_grf_bypass;

   logic clk;
   logic reset;
   int   tests;
   int   fails;

   grf_bypass_if #(.DATA_W(32)) bus ();

   grf_bypass #(.DATA_W(32), .NREG(32), .RESET_VAL(32'h0)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [31:0] model [32];
   logic        exp_tv;
   logic [31:0] exp_tpc;
   logic [4:0]  exp_treg;
   logic [31:0] exp_tdata;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed running, required done");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [4:0] a);
      if (a == 5'd0) return 32'h0;
      if (bus.we && bus.a3 == a) return bus.wd;
      return model[a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      exp_tv = 1'b0; exp_tpc = '0; exp_treg = '0; exp_tdata = '0;
   endtask

   task automatic check_trace(input string tag);
      check({tag, ".tv"},    64'(bus.trace_valid), 64'(exp_tv));
      check({tag, ".tpc"},   64'(bus.trace_pc),    64'(exp_tpc));
      check({tag, ".treg"},  64'(bus.trace_reg),   64'(exp_treg));
      check({tag, ".tdata"}, 64'(bus.trace_data),  64'(exp_tdata));
   endtask

   // Checks reads before the edge, clocks once, then checks the trace record
   task automatic do_cycle(input string tag);
      #1;
      check({tag, ".rd1"}, 64'(bus.rd1), 64'(model_read(bus.a1)));
      check({tag, ".rd2"}, 64'(bus.rd2), 64'(model_read(bus.a2)));
      exp_tv = bus.we && (bus.a3 != 5'd0);
      if (exp_tv) begin
         exp_tpc = bus.pc; exp_treg = bus.a3; exp_tdata = bus.wd;
         model[bus.a3] = bus.wd;
      end
      @(posedge clk);
      #1;
      check_trace(tag);
   endtask

   task automatic drive(input logic we, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
      bus.we = we; bus.a1 = a1; bus.a2 = a2; bus.a3 = a3; bus.wd = wd; bus.pc = pc;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      reset = 1'b1;
      drive(1'b0, 5'd5, 5'd0, 5'd0, 32'h0, 32'h0);
      model_reset();
      #2;
      check("por.rd1", 64'(bus.rd1), 64'h0);
      check_trace("por");
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // reset mid-cycle after writing $5
      drive(1'b1, 5'd5, 5'd0, 5'd5, 32'hDEAD_BEEF, 32'h0000_1000);
      do_cycle("w5");
      drive(1'b0, 5'd5, 5'd0, 5'd0, 32'h0, 32'h0);
      #1;
      check("w5.rd1", 64'(bus.rd1), 64'hDEAD_BEEF);
      #1;
      reset = 1'b1;
      #1;
      model_reset();
      check("rst_mid.rd1", 64'(bus.rd1), 64'h0);
      check_trace("rst_mid");
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      check_trace("rst_mid_after");

      // basic write/read
      drive(1'b1, 5'd0, 5'd0, 5'd8, 32'h0000_1234, 32'h0000_3000);
      do_cycle("basic_w");
      check("basic.tv", 64'(bus.trace_valid), 64'h1);
      check("basic.treg", 64'(bus.trace_reg), 64'd8);
      check("basic.tpc", 64'(bus.trace_pc), 64'h3000);
      check("basic.tdata", 64'(bus.trace_data), 64'h1234);
      drive(1'b0, 5'd8, 5'd0, 5'd0, 32'h0, 32'h0);
      #1;
      check("basic.rd1", 64'(bus.rd1), 64'h1234);
      do_cycle("basic_r");
      check("basic.tv_drop", 64'(bus.trace_valid), 64'h0);

      // $0 hardwire
      drive(1'b1, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h0000_3004);
      #1;
      check("r0.rd1_pre", 64'(bus.rd1), 64'h0);
      do_cycle("r0");
      check("r0.rd1_post", 64'(bus.rd1), 64'h0);
      check("r0.tv", 64'(bus.trace_valid), 64'h0);

      // bypass
      drive(1'b1, 5'd0, 5'd0, 5'd9, 32'h11, 32'h0000_3008);
      do_cycle("byp_init");
      drive(1'b1, 5'd9, 5'd9, 5'd9, 32'h22, 32'h0000_300C);
      #1;
      check("byp.rd1_pre", 64'(bus.rd1), 64'h22);
      check("byp.rd2_pre", 64'(bus.rd2), 64'h22);
      do_cycle("byp");
      drive(1'b0, 5'd9, 5'd9, 5'd0, 32'h0, 32'h0);
      #1;
      check("byp.rd1_post", 64'(bus.rd1), 64'h22);
      check("byp.rd2_post", 64'(bus.rd2), 64'h22);
      do_cycle("byp_hold");

      // back-to-back writes to $31
      drive(1'b1, 5'd0, 5'd0, 5'd31, 32'hA, 32'h0000_3010);
      do_cycle("b2b_a");
      check("b2b_a.tdata", 64'(bus.trace_data), 64'hA);
      drive(1'b1, 5'd0, 5'd0, 5'd31, 32'hB, 32'h0000_3014);
      do_cycle("b2b_b");
      check("b2b_b.tv", 64'(bus.trace_valid), 64'h1);
      check("b2b_b.tdata", 64'(bus.trace_data), 64'hB);
      drive(1'b0, 5'd31, 5'd0, 5'd0, 32'h0, 32'h0);
      #1;
      check("b2b.rd1", 64'(bus.rd1), 64'hB);
      do_cycle("b2b_idle");

      // reset across a write edge
      drive(1'b1, 5'd4, 5'd0, 5'd4, 32'h77, 32'h0000_3018);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive(1'b0, 5'd4, 5'd0, 5'd0, 32'h0, 32'h0);
      model_reset();
      #1;
      check("rstw.tv", 64'(bus.trace_valid), 64'h0);
      check("rstw.rd1", 64'(bus.rd1), 64'h0);
      do_cycle("rstw_idle");

      // randomized traffic against the model
      for (int n = 0; n < 300; n++) begin
         logic [4:0] r3;
         r3 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         drive(1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0) ? r3 : 5'($urandom_range(0, 31)),
               ($urandom_range(0, 3) == 0) ? r3 : 5'($urandom_range(0, 31)),
               r3, $urandom, $urandom);
         do_cycle("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
